// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-controller bundle: ID/EX/MEM status in, pipeline enables/flushes out
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       idRs1;
   logic [4:0]       idRs2;
   logic             idUseRs1;
   logic             idUseRs2;
   logic [4:0]       exRd;
   logic             exRw;
   logic             exMemRead;
   logic             exMulDiv;
   logic             exBranchTaken;
   logic             mdDone;
   logic             memReq;
   logic             memReady;
   logic             pcWrite;
   logic             ifIdWrite;
   logic             ifIdFlush;
   logic             idExWrite;
   logic             idExFlush;
   logic             exMemWrite;
   logic             exMemFlush;
   logic             memWbWrite;
   logic             mdStart;
   logic             mdErr;
   logic [CNT_W-1:0] stallCycles;
   logic [CNT_W-1:0] flushCount;

   modport master (
      output idRs1, idRs2, idUseRs1, idUseRs2, exRd, exRw, exMemRead, exMulDiv,
             exBranchTaken, mdDone, memReq, memReady,
      input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite,
             exMemFlush, memWbWrite, mdStart, mdErr, stallCycles, flushCount
   );

   modport slave (
      input  idRs1, idRs2, idUseRs1, idUseRs2, exRd, exRw, exMemRead, exMulDiv,
             exBranchTaken, mdDone, memReq, memReady,
      output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite,
             exMemFlush, memWbWrite, mdStart, mdErr, stallCycles, flushCount
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for load-use, branch, mul/div and memory-wait hazards
module pipeline_hazard_ctrl #(
   parameter int CNT_W  = 32,
   parameter int MD_MAX = 64
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int WD_W = $clog2(MD_MAX);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX - 1);

   typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

   state_t           state, state_nxt;
   logic [WD_W-1:0]  wd;
   logic             md_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             freeze, load_use, md_timeout, md_finish;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic             ex_mem_write, ex_mem_flush, mem_wb_write, md_start;
   logic             wd_clr, err_set, br_flush;

   assign freeze     = hz.memReq & ~hz.memReady;
   assign md_timeout = (wd == WD_LAST);
   assign md_finish  = hz.mdDone | md_timeout;
   assign load_use   = hz.exMemRead & hz.exRw & (hz.exRd != 5'd0) &
                       ((hz.idUseRs1 & (hz.idRs1 == hz.exRd)) |
                        (hz.idUseRs2 & (hz.idRs2 == hz.exRd)));

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      ex_mem_flush = 1'b0;
      mem_wb_write = 1'b1;
      md_start     = 1'b0;
      state_nxt    = state;
      wd_clr       = 1'b0;
      err_set      = 1'b0;
      br_flush     = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         // A result arriving during a memory wait is parked in MD_DONE until the wait ends.
         if (state == MD_BUSY && md_finish) begin
            state_nxt = MD_DONE;
            err_set   = md_timeout & ~hz.mdDone;
         end
      end else begin
         case (state)
            RUN: begin
               if (hz.exMulDiv) begin
                  md_start     = 1'b1;
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_write  = 1'b0;
                  ex_mem_flush = 1'b1;
                  state_nxt    = MD_BUSY;
                  wd_clr       = 1'b1;
               end else if (hz.exBranchTaken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  br_flush    = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_finish) begin
                  state_nxt = RUN;
                  err_set   = md_timeout & ~hz.mdDone;
               end else begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_write  = 1'b0;
                  ex_mem_flush = 1'b1;
               end
            end
            MD_DONE: state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wd        <= '0;
         md_err    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (wd_clr)
            wd <= '0;
         else if (state == MD_BUSY && !md_timeout)
            wd <= wd + 1'b1;
         if (err_set)
            md_err <= 1'b1;
         if (!pc_write && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (br_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign hz.pcWrite     = pc_write;
   assign hz.ifIdWrite   = if_id_write;
   assign hz.ifIdFlush   = if_id_flush;
   assign hz.idExWrite   = id_ex_write;
   assign hz.idExFlush   = id_ex_flush;
   assign hz.exMemWrite  = ex_mem_write;
   assign hz.exMemFlush  = ex_mem_flush;
   assign hz.memWbWrite  = mem_wb_write;
   assign hz.mdStart     = md_start;
   assign hz.mdErr       = md_err;
   assign hz.stallCycles = stall_cnt;
   assign hz.flushCount  = flush_cnt;
endmodule
